s2sram_bw: RTL and testbench

Parametrised simple dual-port SRAM with per-byte write enables, selectable read latency, optional same-cycle write-to-read forwarding, and a post-reset clear sequencer. Next-generation buffer for the MEL datapath: one synchronous write port, one synchronous read port, one clock. Downstream logic uses `rd_valid` instead of counting cycles, and must not access the block before `init_done`.

---
 rtl/s2sram_pkg.sv | 29 ++
 rtl/s2sram_init_fsm.sv | 49 ++++
 rtl/s2sram_bw.sv | 141 ++++++++++++++
 tb/tb_s2sram_bw.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2sram_pkg.sv
// Shared types, latency limits and the byte-lane merge helper for the s2sram_bw buffer.
package s2sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } s2sram_state_e;

    localparam int S2SRAM_LAT_MIN = 1;
    localparam int S2SRAM_LAT_MAX = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int S2SRAM_MERGE_W = 256;

    // Per-bit select: a bit takes new_word when the enable of its lane is set.
    function automatic logic [S2SRAM_MERGE_W-1:0] s2sram_byte_merge(
        input logic [S2SRAM_MERGE_W-1:0] old_word,
        input logic [S2SRAM_MERGE_W-1:0] new_word,
        input logic [S2SRAM_MERGE_W-1:0] be,
        input int                        byte_w
    );
        logic [S2SRAM_MERGE_W-1:0] res;
        for (int b = 0; b < S2SRAM_MERGE_W; b++) begin
            res[b] = be[b / byte_w] ? new_word[b] : old_word[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/s2sram_init_fsm.sv
// Post-reset clear sequencer: walks every address once with an all-zero write,
// then raises init_done and stays READY until the next reset.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   CLEAR | zeroing address clr_addr this cycle; user port is blocked
//   READY | array usable; terminal until reset
module s2sram_init_fsm
    import s2sram_pkg::*;
#(
    parameter  int DEPTH      = 512,
    parameter  int INIT_CLEAR = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    s2sram_state_e state;

    // Clear walk: one address per edge, READY on the edge that writes the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (INIT_CLEAR != 0) ? CLEAR : READY;
            clr_addr  <= '0;
            clr_en    <= (INIT_CLEAR != 0);
            init_done <= (INIT_CLEAR == 0);
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state     <= READY;
                        clr_en    <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

endmodule

// File: rtl/s2sram_bw.sv
// Simple dual-port SRAM with byte-lane write enables, 1- or 2-cycle read latency
// and a post-reset clear. Define S2SRAM_BYPASS_EN for write-first behaviour on a
// same-cycle read/write address match; otherwise reads see pre-write contents.
module s2sram_bw
    import s2sram_pkg::*;
#(
    parameter  int DEPTH      = 512,
    parameter  int WIDTH      = 32,
    parameter  int BYTE_W     = 8,
    parameter  int RD_LAT     = 1,
    parameter  int INIT_CLEAR = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int NB         = WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid
);

    if (WIDTH % BYTE_W != 0) begin : g_chk_width
        $error("s2sram_bw: WIDTH must be a multiple of BYTE_W");
    end
    if (RD_LAT < S2SRAM_LAT_MIN || RD_LAT > S2SRAM_LAT_MAX) begin : g_chk_lat
        $error("s2sram_bw: RD_LAT must be 1 or 2");
    end

    // One extra bit so the bound stays representable when DEPTH is a power of 2.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  usr_wr;
    logic                  usr_rd;
    logic                  port_we;
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [NB-1:0]         port_be;
    logic [WIDTH-1:0]      port_data;
    logic [WIDTH-1:0]      rd_word;
    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_data;
    logic [WIDTH-1:0]      mem [DEPTH];

    s2sram_init_fsm #(
        .DEPTH      (DEPTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_init_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
    assign usr_wr      = init_done & wr_en & wr_in_range;
    assign usr_rd      = init_done & rd_en;

    // Write port mux: the clear sequencer owns the port until init_done.
    always_comb begin
        port_we   = usr_wr;
        port_addr = wr_addr;
        port_be   = wr_be;
        port_data = wr_data;
        if (clr_en) begin
            port_we   = 1'b1;
            port_addr = clr_addr;
            port_be   = '1;
            port_data = '0;
        end
    end

    // Array write with per-lane enables; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (port_we) begin
            for (int i = 0; i < NB; i++) begin
                if (port_be[i]) begin
                    mem[port_addr][i*BYTE_W +: BYTE_W] <= port_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read word selection: out-of-range reads return zero; optional write-first forwarding.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
`ifdef S2SRAM_BYPASS_EN
            if (usr_wr && (wr_addr == rd_addr)) begin
                rd_word = WIDTH'(s2sram_byte_merge(S2SRAM_MERGE_W'(mem[rd_addr]),
                                                   S2SRAM_MERGE_W'(wr_data),
                                                   S2SRAM_MERGE_W'(wr_be),
                                                   BYTE_W));
            end
`endif
        end
    end

    // Stage 1 captures the read result at acceptance, so later writes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= usr_rd;
            if (usr_rd) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        // Output register stage; data holds while no new result arrives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    rd_data <= s1_data;
                end
            end
        end
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_s2sram_bw.sv
// Bench for s2sram_bw: four instances share one stimulus stream
// (u0: DEPTH 16 lat 1, u1: DEPTH 16 lat 2, u2: DEPTH 12 lat 1, u3: no clear).
module tb_s2sram_bw;

    localparam int NI = 4;
    localparam int AW = 4;

`ifdef S2SRAM_BYPASS_EN
    localparam logic [31:0] FWD_EXP = 32'h0000BEEF;
`else
    localparam logic [31:0] FWD_EXP = 32'h00000000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [NI-1:0] init_done;
    logic [NI-1:0] rd_valid;
    logic [31:0]   rd_data [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    s2sram_bw #(.DEPTH(16), .WIDTH(32), .BYTE_W(8), .RD_LAT(1), .INIT_CLEAR(1)) u0 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]));

    s2sram_bw #(.DEPTH(16), .WIDTH(32), .BYTE_W(8), .RD_LAT(2), .INIT_CLEAR(1)) u1 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]));

    s2sram_bw #(.DEPTH(12), .WIDTH(32), .BYTE_W(8), .RD_LAT(1), .INIT_CLEAR(1)) u2 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]));

    s2sram_bw #(.DEPTH(16), .WIDTH(32), .BYTE_W(8), .RD_LAT(1), .INIT_CLEAR(0)) u3 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done[3]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[3]), .rd_valid(rd_valid[3]));

    // ---------------- behavioural model ----------------
    int          m_depth [NI] = '{16, 16, 12, 16};
    int          m_lat   [NI] = '{1, 2, 1, 1};
    int          m_clear [NI] = '{1, 1, 1, 0};
    logic [31:0] m_mem   [NI][16];
    int          m_cnt   [NI];
    bit          m_ready [NI];
    bit          slot_v  [NI][4];
    logic [31:0] slot_d  [NI][4];
    logic [31:0] exp_data[NI];
    int          ec = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = n[l*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cnt[k]    = 0;
            m_ready[k]  = (m_clear[k] == 0);
            exp_data[k] = '0;
            for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        logic [31:0] v;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (!m_ready[k]) begin
                    m_mem[k][m_cnt[k]] = '0;
                    m_cnt[k]++;
                    if (m_cnt[k] == m_depth[k]) m_ready[k] = 1'b1;
                end else begin
                    if (rd_en) begin
                        v = '0;
                        if (int'(rd_addr) < m_depth[k]) begin
                            v = m_mem[k][rd_addr];
`ifdef S2SRAM_BYPASS_EN
                            if (wr_en && wr_addr == rd_addr) v = merge(v, wr_data, wr_be);
`endif
                        end
                        slot_v[k][(ec + m_lat[k] - 1) % 4] = 1'b1;
                        slot_d[k][(ec + m_lat[k] - 1) % 4] = v;
                    end
                    if (wr_en && int'(wr_addr) < m_depth[k])
                        m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_data, wr_be);
                end
            end
            ec++;
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        int idx;
        bit ev;
        idx = (ec - 1) & 3;
        for (int k = 0; k < NI; k++) begin
            ev = slot_v[k][idx];
            if (ev) begin
                exp_data[k]     = slot_d[k][idx];
                slot_v[k][idx] = 1'b0;
            end
            total++;
            if (rd_valid[k] !== ev) begin
                bad++;
                $display("FAIL rd_valid u%0d t=%0t got=%b exp=%b", k, $time, rd_valid[k], ev);
            end
            total++;
            if (init_done[k] !== m_ready[k]) begin
                bad++;
                $display("FAIL init_done u%0d t=%0t got=%b exp=%b", k, $time, init_done[k], m_ready[k]);
            end
            if (k < 3) begin
                total++;
                if (rd_data[k] !== exp_data[k]) begin
                    bad++;
                    $display("FAIL rd_data u%0d t=%0t got=%h exp=%h", k, $time, rd_data[k], exp_data[k]);
                end
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = 4'h0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    initial begin
        bit [4:0]    vseq;
        logic [31:0] dseq [5];

        rst_n = 1'b0;
        idle();
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_init_done_u0", 32'(init_done[0]), 32'd0);
        chk("reset_init_done_u3", 32'(init_done[3]), 32'd1);
        chk("reset_rd_data_u1", rd_data[1], 32'd0);

        // Clear with reads requested, then reset at cnt=7 with u3 reads in flight.
        rd_en = 1'b1; rd_addr = 4'd2;
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        chk("u3_read_in_flight", 32'(rd_valid[3]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("async_rst_valid_u%0d", k), 32'(rd_valid[k]), 32'd0);
            chk($sformatf("async_rst_data_u%0d", k), rd_data[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("clear_not_done_15", 32'(init_done[0]), 32'd0);
        chk("clear_done_depth12", 32'(init_done[2]), 32'd1);
        @(negedge clk);
        chk("clear_done_16", 32'(init_done[0]), 32'd1);
        chk("no_valid_during_clear", 32'(rd_valid[0]), 32'd0);
        idle();
        @(negedge clk);

        // Every address reads zero after clear.
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            @(negedge clk);
            chk($sformatf("cleared_addr%0d", a), rd_data[0], 32'd0);
        end
        idle();
        @(negedge clk);

        // Byte enables.
        wr(4'd5, 32'hAABBCCDD, 4'hF);
        @(negedge clk);
        wr(4'd5, 32'h11223344, 4'b0101);
        @(negedge clk);
        idle(); rd_en = 1'b1; rd_addr = 4'd5;
        @(negedge clk);
        idle();
        chk("byte_en_u0", rd_data[0], 32'hAA22CC44);
        @(negedge clk);
        chk("byte_en_u1", rd_data[1], 32'hAA22CC44);

        // Same-cycle write/read on address 3.
        wr(4'd3, 32'hDEADBEEF, 4'b0011);
        rd_en = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        idle();
        chk("forward_u0", rd_data[0], FWD_EXP);
        rd_en = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        idle();
        chk("after_forward_u0", rd_data[0], 32'h0000BEEF);
        @(negedge clk);

        // Latency 2: three back-to-back reads, later write to address 1.
        wr(4'd0, 32'h10, 4'hF); @(negedge clk);
        wr(4'd1, 32'h11, 4'hF); @(negedge clk);
        wr(4'd2, 32'h12, 4'hF); @(negedge clk);
        idle(); @(negedge clk);
        rd_en = 1'b1; rd_addr = 4'd0;
        @(negedge clk); vseq[0] = rd_valid[1]; dseq[0] = rd_data[1];
        rd_addr = 4'd1;
        @(negedge clk); vseq[1] = rd_valid[1]; dseq[1] = rd_data[1];
        rd_addr = 4'd2; wr(4'd1, 32'h99, 4'hF);
        @(negedge clk); vseq[2] = rd_valid[1]; dseq[2] = rd_data[1];
        idle();
        @(negedge clk); vseq[3] = rd_valid[1]; dseq[3] = rd_data[1];
        @(negedge clk); vseq[4] = rd_valid[1]; dseq[4] = rd_data[1];
        chk("lat2_valid_seq", 32'(vseq), 32'b01110);
        chk("lat2_data0", dseq[1], 32'h10);
        chk("lat2_data1", dseq[2], 32'h11);
        chk("lat2_data2", dseq[3], 32'h12);
        chk("lat2_hold", dseq[4], 32'h12);

        // Out-of-range on the 12-deep instance; wr_be=0 is a no-op.
        wr(4'd13, 32'hFFFFFFFF, 4'hF); @(negedge clk);
        wr(4'd0, 32'hCAFEF00D, 4'h0); @(negedge clk);
        idle(); rd_en = 1'b1; rd_addr = 4'd13;
        @(negedge clk);
        chk("oor_valid_u2", 32'(rd_valid[2]), 32'd1);
        chk("oor_data_u2", rd_data[2], 32'd0);
        chk("inrange13_u0", rd_data[0], 32'hFFFFFFFF);
        rd_addr = 4'd1;
        @(negedge clk);
        chk("addr1_unchanged_u2", rd_data[2], 32'h99);
        rd_addr = 4'd0;
        @(negedge clk);
        idle();
        chk("be_zero_noop_u0", rd_data[0], 32'h10);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
